// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 keyboard receiver with E0/F0 prefix decode and a held-key bitmap
// Ports: clk/rst (sync, active-high); ps2_clk/ps2_data raw async keyboard lines;
// keys held bitmap (bit i = KEYMAP entry i); code_valid pulse with code/code_ext/code_break;
// frame_err pulse on parity/stop/timeout error; err_count saturating error count.
// Optional macro PS2_ERR_RELEASE_EN: a frame error also releases every key.
module ps2_key_tracker #(
  parameter int NUM_PLAYERS     = 2,
  parameter int KEYS_PER_PLAYER = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_LEN      = 4,
  parameter int TIMEOUT_CYCLES  = 25000,
  // entry 0 sits in the low 9 bits: {ext, code}
  parameter logic [9*NUM_PLAYERS*KEYS_PER_PLAYER-1:0] KEYMAP =
    {9'h029, 9'h172, 9'h174, 9'h16B, 9'h175, 9'h00D, 9'h01B, 9'h01C, 9'h023, 9'h01D}
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ps2_clk,
  input  logic                                   ps2_data,
  output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] keys,
  output logic                                   code_valid,
  output logic [7:0]                             code,
  output logic                                   code_ext,
  output logic                                   code_break,
  output logic                                   frame_err,
  output logic [7:0]                             err_count
);
  localparam int NK = NUM_PLAYERS * KEYS_PER_PLAYER;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [SYNC_STAGES-1:0] r_csync, r_dsync;
  logic                   r_filt;
  logic [FW-1:0]          r_fcnt;
  state_t                 r_state;
  logic [7:0]             r_shift;
  logic [2:0]             r_bitcnt;
  logic                   r_par, r_ext, r_brk;
  logic [TW-1:0]          r_tcnt;
  logic                   w_cs, w_ds, w_flip, w_fall, w_frame_ok, w_err, w_prefix;
  logic [NK-1:0]          w_hit;
  assign w_cs       = r_csync[SYNC_STAGES-1];
  assign w_ds       = r_dsync[SYNC_STAGES-1];
  // filtered clock flips once the synchronised level has differed for FILTER_LEN samples
  assign w_flip     = (w_cs != r_filt) && (r_fcnt == FW'(FILTER_LEN - 1));
  assign w_fall     = w_flip && r_filt;
  assign w_frame_ok = w_ds && (^{r_shift, r_par});
  assign w_err      = (w_fall && r_state == STOP && !w_frame_ok) ||
                      (!w_fall && r_state != IDLE && r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_prefix   = (r_shift == 8'hE0) || (r_shift == 8'hF0);
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NK; i++) w_hit[i] = KEYMAP[9*i +: 9] == {r_ext, r_shift};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csync <= '1;
      r_dsync <= '1;
      r_filt  <= 1'b1;
      r_fcnt  <= '0;
    end else begin
      r_csync <= {r_csync[SYNC_STAGES-2:0], ps2_clk};
      r_dsync <= {r_dsync[SYNC_STAGES-2:0], ps2_data};
      r_fcnt  <= (w_cs == r_filt || w_flip) ? '0 : r_fcnt + 1'b1;
      if (w_flip) r_filt <= w_cs;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_par      <= 1'b0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_tcnt     <= '0;
      keys       <= '0;
      code_valid <= 1'b0;
      code       <= '0;
      code_ext   <= 1'b0;
      code_break <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      code_valid <= w_fall && r_state == STOP && w_frame_ok && !w_prefix;
      frame_err  <= w_err;
      r_tcnt     <= (w_fall || r_state == IDLE) ? '0 : r_tcnt + 1'b1;
      if (w_err) begin
        r_state   <= IDLE;
        r_ext     <= 1'b0;
        r_brk     <= 1'b0;
        err_count <= err_count + 8'(err_count != 8'hFF);
`ifdef PS2_ERR_RELEASE_EN
        keys      <= '0;
`else
        keys      <= keys;
`endif
      end else if (w_fall) begin
        case (r_state)
          IDLE: if (!w_ds) begin
            r_state  <= DATA;
            r_bitcnt <= '0;
          end
          DATA: begin
            r_shift  <= {w_ds, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= w_ds;
            r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (r_shift == 8'hE0) r_ext <= 1'b1;
            else if (r_shift == 8'hF0) r_brk <= 1'b1;
            else begin
              code       <= r_shift;
              code_ext   <= r_ext;
              code_break <= r_brk;
              r_ext      <= 1'b0;
              r_brk      <= 1'b0;
              keys       <= r_brk ? (keys & ~w_hit) : (keys | w_hit);
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: frame-level reference model check of ps2_key_tracker
module tb_ps2_key_tracker;
  localparam int TO = 300;
  logic       clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1;
  logic [9:0] keys;
  logic       code_valid, code_ext, code_break, frame_err;
  logic [7:0] code, err_count;
  ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keys(keys), .code_valid(code_valid), .code(code), .code_ext(code_ext),
    .code_break(code_break), .frame_err(frame_err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_bad = 0, n_cv = 0, n_fe = 0, hp = 20;
  int m_ncv = 0, m_nfe = 0;
  logic [9:0] m_keys = '0;
  logic       m_ext = 0, m_brk = 0, m_cext = 0, m_cbrk = 0;
  logic [7:0] m_code = '0, m_err = '0;
  int unsigned keymap [10] = '{'h01D, 'h023, 'h01C, 'h01B, 'h00D, 'h175, 'h16B, 'h174, 'h172, 'h029};
  always @(negedge clk) begin
    if (code_valid) n_cv++;
    if (frame_err) n_fe++;
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(string tag);
    chk({tag, ".keys"}, 32'(keys), 32'(m_keys));
    chk({tag, ".code"}, 32'(code), 32'(m_code));
    chk({tag, ".ext"}, 32'(code_ext), 32'(m_cext));
    chk({tag, ".brk"}, 32'(code_break), 32'(m_cbrk));
    chk({tag, ".errcnt"}, 32'(err_count), 32'(m_err));
    chk({tag, ".n_valid"}, n_cv, m_ncv);
    chk({tag, ".n_err"}, n_fe, m_nfe);
  endtask
  function automatic void model_err();
    m_nfe++;
    m_err = (m_err == 8'd255) ? 8'd255 : m_err + 8'd1;
    m_ext = 0;
    m_brk = 0;
`ifdef PS2_ERR_RELEASE_EN
    m_keys = '0;
`endif
  endfunction
  function automatic void model_byte(logic [7:0] b, bit ok);
    if (!ok) model_err();
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      m_ncv++;
      m_code = b;
      m_cext = m_ext;
      m_cbrk = m_brk;
      for (int i = 0; i < 10; i++) if (keymap[i] == {23'd0, m_ext, b}) m_keys[i] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endfunction
  function automatic void model_reset();
    m_keys = '0; m_ext = 0; m_brk = 0; m_cext = 0; m_cbrk = 0; m_code = '0; m_err = '0;
  endfunction
  task automatic send_bits(logic [10:0] f, int nbits, bit glitch);
    for (int b = 0; b < nbits; b++) begin
      ps2_data = f[b];
      cyc(hp / 2);
      if (glitch) begin ps2_clk = 0; cyc($urandom_range(1, 3)); ps2_clk = 1; end
      cyc(hp / 2);
      ps2_clk = 0;
      cyc(hp / 2);
      if (glitch) begin ps2_clk = 1; cyc($urandom_range(1, 3)); ps2_clk = 0; end
      cyc(hp / 2);
      ps2_clk = 1;
    end
    ps2_data = 1;
  endtask
  task automatic frame(logic [7:0] b, bit bad_par = 0, bit bad_stop = 0, bit glitch = 0);
    logic par;
    par = (~^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11, glitch);
    cyc(2 * hp);
    model_byte(b, !bad_par && !bad_stop);
  endtask
  initial begin
    logic [7:0] b;
    int r;
    cyc(4);
    chk("rst.valid", 32'(code_valid), 0);
    chk("rst.ferr", 32'(frame_err), 0);
    check_all("rst");
    rst = 0;
    cyc(4);
    frame(8'h1D); check_all("make_1d");
    frame(8'hF0); frame(8'h1D); check_all("break_1d");
    frame(8'hE0); frame(8'h75); check_all("make_e075");
    frame(8'hE0); frame(8'hF0); frame(8'h75); check_all("break_e0f075");
    frame(8'h75); check_all("plain_75");
    frame(8'hE0); frame(8'h75); frame(8'hF0); frame(8'hE0); frame(8'h75); check_all("break_f0e075");
    frame(8'h29, 1, 0); check_all("bad_parity");
    frame(8'h29, 0, 1); check_all("bad_stop");
    send_bits({1'b1, ~^8'h1D, 8'h1D, 1'b0}, 5, 0);
    cyc(TO + 50);
    model_err(); check_all("timeout");
    frame(8'h1C); check_all("after_timeout");
    for (int i = 0; i < 4; i++) begin
      frame(8'(keymap[$urandom_range(0, 4)]), 0, 0, 1);
      check_all("glitch");
    end
    frame(8'h1D); frame(8'hE0); frame(8'h75); check_all("hold_w_up");
    frame(8'h3A, 1, 0); check_all("err_release");
    send_bits({1'b1, ~^8'h23, 8'h23, 1'b0}, 6, 0);
    rst = 1;
    cyc(3);
    model_reset();
    chk("midrst.valid", 32'(code_valid), 0);
    chk("midrst.ferr", 32'(frame_err), 0);
    check_all("midrst");
    rst = 0;
    cyc(4);
    frame(8'h23); check_all("after_rst");
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : (r < 8) ? 8'(keymap[$urandom_range(0, 9)]) : 8'($urandom);
      r = $urandom_range(0, 9);
      frame(b, r == 0, r == 1);
      check_all("random");
    end
    hp = 6;
    repeat (260) frame(8'h00, 1, 0);
    hp = 20;
    check_all("saturate");
    frame(8'h1B); check_all("after_saturate");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
